csr_read_unit: RTL and testbench

Read side of the machine-mode CSR file. Accepts CSR access requests from the execute stage, decodes the 12-bit CSR address, returns the old value of the addressed CSR for rd write-back, and flags illegal accesses. Owns the 64-bit cycle and instret counters, which are read as 32-bit halves through a snapshot mechanism. The writable CSRs (mstatus, mtvec, mepc, mcause, mscratch) live in the CSR flop registers elsewhere; their Q outputs feed this block.

---
 rtl/csr_read_unit_pkg.sv | 63 ++++++
 rtl/csr_read_unit_if.sv | 35 +++
 rtl/csr_counter64.sv | 30 +++
 rtl/csr_read_unit.sv | 128 ++++++++++++
 tb/tb_csr_read_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/csr_read_unit_pkg.sv
// Shared CSR definitions: address map, decoded target select and access-legality helpers.
// Used by the CSR read unit, the instruction decoder and the CSR write logic.
package csr_read_unit_pkg;

    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrMcycleh   = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;
    localparam logic [11:0] CsrCycle     = 12'hC00;
    localparam logic [11:0] CsrInstret   = 12'hC02;
    localparam logic [11:0] CsrCycleh    = 12'hC80;
    localparam logic [11:0] CsrInstreth  = 12'hC82;

    typedef enum logic [3:0] {
        SelNone,
        SelMstatus,
        SelMtvec,
        SelMscratch,
        SelMepc,
        SelMcause,
        SelCycleLo,
        SelCycleHi,
        SelInstretLo,
        SelInstretHi
    } csr_sel_t;

    // User-level counter aliases map onto the same targets as the machine-level ones.
    function automatic csr_sel_t csr_decode(input logic [11:0] addr);
        csr_sel_t sel;
        case (addr)
            CsrMstatus:                 sel = SelMstatus;
            CsrMtvec:                   sel = SelMtvec;
            CsrMscratch:                sel = SelMscratch;
            CsrMepc:                    sel = SelMepc;
            CsrMcause:                  sel = SelMcause;
            CsrMcycle,   CsrCycle:      sel = SelCycleLo;
            CsrMcycleh,  CsrCycleh:     sel = SelCycleHi;
            CsrMinstret, CsrInstret:    sel = SelInstretLo;
            CsrMinstreth, CsrInstreth:  sel = SelInstretHi;
            default:                    sel = SelNone;
        endcase
        return sel;
    endfunction

    function automatic logic csr_is_counter(input csr_sel_t sel);
        return (sel == SelCycleLo) || (sel == SelCycleHi) ||
               (sel == SelInstretLo) || (sel == SelInstretHi);
    endfunction

    // Counters are read-only, and the [11:10]==2'b11 region is read-only by encoding.
    function automatic logic csr_is_illegal(input csr_sel_t sel, input logic [11:0] addr,
                                            input logic write);
        logic ro_region;
        ro_region = (addr[11:10] == 2'b11);
        return (sel == SelNone) || (write && ro_region) || (write && csr_is_counter(sel));
    endfunction

endpackage

// File: rtl/csr_read_unit_if.sv
// Request/response handshake between the execute stage and the CSR read unit.
interface csr_read_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ReqValid;
    logic             ReqReady;
    logic [11:0]      ReqAddr;
    logic             ReqWrite;
    logic             RespValid;
    logic             RespReady;
    logic [WIDTH-1:0] RespData;
    logic             RespIllegal;

    modport master (
        output ReqValid,
        output ReqAddr,
        output ReqWrite,
        output RespReady,
        input  ReqReady,
        input  RespValid,
        input  RespData,
        input  RespIllegal
    );

    modport slave (
        input  ReqValid,
        input  ReqAddr,
        input  ReqWrite,
        input  RespReady,
        output ReqReady,
        output RespValid,
        output RespData,
        output RespIllegal
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with synchronous reset and increment enable, read as two words.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] lo,
    output logic [31:0] hi
);
    logic [63:0] count_q;
    logic [63:0] count_d;

    // Natural 64-bit overflow gives the wrap from all-ones to zero.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign lo = count_q[31:0];
    assign hi = count_q[63:32];
endmodule

// File: rtl/csr_read_unit.sv
// Read side of the machine-mode CSR file: decodes the address, returns the old CSR value,
// flags illegal accesses and owns the cycle/instret counters with high-word snapshots.
module csr_read_unit
    import csr_read_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    csr_read_unit_if.slave   bus,
    input  logic             RetireValid,
    input  logic [WIDTH-1:0] MStatus,
    input  logic [WIDTH-1:0] MTvec,
    input  logic [WIDTH-1:0] MEpc,
    input  logic [WIDTH-1:0] MCause,
    input  logic [WIDTH-1:0] MScratch
);
    logic [31:0] cycle_lo;
    logic [31:0] cycle_hi;
    logic [31:0] instret_lo;
    logic [31:0] instret_hi;

    logic [31:0] cycle_shadow_q;
    logic [31:0] cycle_shadow_d;
    logic [31:0] instret_shadow_q;
    logic [31:0] instret_shadow_d;

    logic             resp_valid_q;
    logic             resp_valid_d;
    logic [WIDTH-1:0] resp_data_q;
    logic [WIDTH-1:0] resp_data_d;
    logic             resp_illegal_q;
    logic             resp_illegal_d;

    csr_sel_t         sel;
    logic             illegal;
    logic             accept;
    logic             req_ready;
    logic [WIDTH-1:0] rdata;

    csr_counter64 u_cycle (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .lo    (cycle_lo),
        .hi    (cycle_hi)
    );

    csr_counter64 u_instret (
        .clk   (clk),
        .reset (reset),
        .en    (RetireValid),
        .lo    (instret_lo),
        .hi    (instret_hi)
    );

    assign sel       = csr_decode(bus.ReqAddr);
    assign illegal   = csr_is_illegal(sel, bus.ReqAddr, bus.ReqWrite);
    assign req_ready = ~resp_valid_q | bus.RespReady;
    assign accept    = bus.ReqValid & req_ready;

    // Counter values come straight from the counter flops, i.e. before this cycle's increment.
    always_comb begin
        rdata = '0;
        if (!illegal) begin
            case (sel)
                SelMstatus:   rdata = MStatus;
                SelMtvec:     rdata = MTvec;
                SelMscratch:  rdata = MScratch;
                SelMepc:      rdata = MEpc;
                SelMcause:    rdata = MCause;
                SelCycleLo:   rdata = cycle_lo;
                SelCycleHi:   rdata = cycle_shadow_q;
                SelInstretLo: rdata = instret_lo;
                SelInstretHi: rdata = instret_shadow_q;
                default:      rdata = '0;
            endcase
        end
    end

    // A legal low-half read freezes the matching high word for the following high-half read.
    always_comb begin
        cycle_shadow_d   = cycle_shadow_q;
        instret_shadow_d = instret_shadow_q;
        if (accept && !illegal) begin
            if (sel == SelCycleLo) begin
                cycle_shadow_d = cycle_hi;
            end
            if (sel == SelInstretLo) begin
                instret_shadow_d = instret_hi;
            end
        end
    end

    always_comb begin
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_illegal_d = resp_illegal_q;
        if (accept) begin
            resp_valid_d   = 1'b1;
            resp_data_d    = rdata;
            resp_illegal_d = illegal;
        end else if (bus.RespReady) begin
            resp_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_shadow_q   <= '0;
            instret_shadow_q <= '0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= '0;
            resp_illegal_q   <= 1'b0;
        end else begin
            cycle_shadow_q   <= cycle_shadow_d;
            instret_shadow_q <= instret_shadow_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            resp_illegal_q   <= resp_illegal_d;
        end
    end

    assign bus.ReqReady    = req_ready;
    assign bus.RespValid   = resp_valid_q;
    assign bus.RespData    = resp_data_q;
    assign bus.RespIllegal = resp_illegal_q;
endmodule

// File: tb/tb_csr_read_unit.sv
// Scoreboard bench for csr_read_unit: a cycle-level reference model predicts each response,
// which is queued at acceptance and compared while it is held at the output.
module tb_csr_read_unit;
    import csr_read_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        retire_valid;
    logic [31:0] mstatus, mtvec, mepc, mcause, mscratch;

    csr_read_unit_if #(.WIDTH(32)) bus ();

    csr_read_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .RetireValid (retire_valid),
        .MStatus     (mstatus),
        .MTvec       (mtvec),
        .MEpc        (mepc),
        .MCause      (mcause),
        .MScratch    (mscratch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        ill;
    } resp_t;

    resp_t       sb_q[$];
    logic [63:0] m_cyc, m_inst;
    logic [31:0] m_cyc_sh, m_inst_sh;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic resp_t model_read(input logic [11:0] a, input logic w);
        resp_t r;
        logic  known, ctr, lo_c, lo_i;
        known = 1'b1; ctr = 1'b0; lo_c = 1'b0; lo_i = 1'b0;
        r.data = 32'h0;
        case (a)
            12'h300: r.data = mstatus;
            12'h305: r.data = mtvec;
            12'h340: r.data = mscratch;
            12'h341: r.data = mepc;
            12'h342: r.data = mcause;
            12'hB00, 12'hC00: begin r.data = m_cyc[31:0];  ctr = 1'b1; lo_c = 1'b1; end
            12'hB80, 12'hC80: begin r.data = m_cyc_sh;     ctr = 1'b1; end
            12'hB02, 12'hC02: begin r.data = m_inst[31:0]; ctr = 1'b1; lo_i = 1'b1; end
            12'hB82, 12'hC82: begin r.data = m_inst_sh;    ctr = 1'b1; end
            default: known = 1'b0;
        endcase
        r.ill = !known || (w && a[11:10] == 2'b11) || (w && ctr);
        if (r.ill) begin
            r.data = 32'h0;
        end else begin
            if (lo_c) m_cyc_sh = m_cyc[63:32];
            if (lo_i) m_inst_sh = m_inst[63:32];
        end
        return r;
    endfunction

    // Drive one cycle's inputs at the falling edge, check the held outputs, then advance the model.
    task automatic cycle(input logic rst, input logic v, input logic [11:0] a, input logic w,
                         input logic rr, input logic ret);
        logic acc;
        @(negedge clk);
        reset = rst; bus.ReqValid = v; bus.ReqAddr = a; bus.ReqWrite = w;
        bus.RespReady = rr; retire_valid = ret;
        #1;
        check_eq("resp_valid", bus.RespValid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
            check_eq("resp_data", bus.RespData, sb_q[0].data);
            check_eq("resp_illegal", bus.RespIllegal, sb_q[0].ill);
        end
        check_eq("req_ready", bus.ReqReady, (sb_q.size() == 0) || rr);
        check_eq("cycle_cnt", {dut.u_cycle.hi, dut.u_cycle.lo}, m_cyc);
        check_eq("instret_cnt", {dut.u_instret.hi, dut.u_instret.lo}, m_inst);
        if (rst) begin
            sb_q.delete();
            m_cyc = 64'h0; m_inst = 64'h0; m_cyc_sh = 32'h0; m_inst_sh = 32'h0;
        end else begin
            acc = v && ((sb_q.size() == 0) || rr);
            if (sb_q.size() != 0 && rr) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(model_read(a, w));
            m_cyc++;
            if (ret) m_inst++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    endtask

    logic [11:0] rd_addrs [8] = '{12'h300, 12'h305, 12'h340, 12'h342, 12'hC80, 12'hB80,
                                  12'h7C0, 12'h123};

    initial begin
        reset = 1'b1; bus.ReqValid = 1'b0; bus.ReqAddr = '0; bus.ReqWrite = 1'b0;
        bus.RespReady = 1'b0; retire_valid = 1'b0;
        mstatus = 32'h0000_1888; mtvec = 32'h8000_0040; mepc = 32'h8000_0104;
        mcause = 32'h8000_000B; mscratch = 32'hDEAD_BEEF;
        m_cyc = 64'h0; m_inst = 64'h0; m_cyc_sh = 32'h0; m_inst_sh = 32'h0;
        repeat (2) @(posedge clk);
        cycle(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);

        // Cycle counter read five cycles out of reset.
        idle(5);
        cycle(1'b0, 1'b1, 12'hC00, 1'b0, 1'b1, 1'b0);
        idle(1);
        check_eq("cycle_at_5", bus.RespData, 64'd5);
        cycle(1'b0, 1'b1, 12'hC80, 1'b0, 1'b1, 1'b0);

        // Writes to read-only counters / read-only region are illegal.
        cycle(1'b0, 1'b1, 12'hC00, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 12'h7C0, 1'b1, 1'b1, 1'b0);
        check_eq("ill_c00_write", bus.RespIllegal, 64'd1);
        idle(1);
        check_eq("ill_7c0_data", bus.RespData, 64'd0);

        // Machine CSRs, legal with and without write intent.
        cycle(1'b0, 1'b1, 12'h341, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 12'h341, 1'b1, 1'b1, 1'b0);
        check_eq("mepc_read", bus.RespData, 64'h8000_0104);
        idle(1);
        check_eq("mepc_write_legal", bus.RespIllegal, 64'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, rd_addrs[i], i[0], 1'b1, i[1]);
        cycle(1'b0, 1'b1, 12'hB00, 1'b1, 1'b1, 1'b0);

        // Backpressure: response held, then back-to-back drain.
        cycle(1'b0, 1'b1, 12'h305, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 12'h342, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, rd_addrs[i], 1'b0, 1'b1, 1'b1);
        idle(2);

        // instret high word rolls over between the low and high reads.
        force dut.u_instret.count_q = 64'h0000_0000_FFFF_FFFD;
        #1;
        release dut.u_instret.count_q;
        m_inst = 64'h0000_0000_FFFF_FFFD;
        cycle(1'b0, 1'b1, 12'hB02, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 12'hB82, 1'b0, 1'b1, 1'b1);
        idle(1);
        check_eq("instreth_shadow", bus.RespData, 64'd0);
        cycle(1'b0, 1'b1, 12'hC02, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 12'hC82, 1'b0, 1'b1, 1'b0);
        idle(1);
        check_eq("instreth_after_low", bus.RespData, 64'd1);

        // Reset with a pending response.
        cycle(1'b0, 1'b1, 12'h340, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        check_eq("valid_after_reset", bus.RespValid, 64'd0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
